// File: rtl/vxe_vpu_cmd_rx_pkg.sv
// Shared definitions for the VPU command receiver: field widths, opcode
// classes, output FSM states and the buffered command record.
package vxe_vpu_cmd_rx_pkg;

  localparam int unsigned OP_W = 5;
  localparam int unsigned TH_W = 3;
  localparam int unsigned PL_W = 48;

  localparam logic [OP_W-1:0] OP_NOP     = 5'b00000;
  localparam logic [OP_W-1:0] OP_BARRIER = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_BARR
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [TH_W-1:0] th;
    logic [PL_W-1:0] pl;
  } cmd_t;

  function automatic logic is_nop(input logic [OP_W-1:0] op);
    return op == OP_NOP;
  endfunction

  function automatic logic is_barrier(input logic [OP_W-1:0] op);
    return op == OP_BARRIER;
  endfunction

  // 10xxx and 11000..11110; BARRIER is the only defined 1xxxx code.
  function automatic logic is_reserved(input logic [OP_W-1:0] op);
    return op[OP_W-1] && (op != OP_BARRIER);
  endfunction

endpackage

// File: rtl/vxe_vpu_cmd_rx_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers for full/empty detection
// and asynchronous active-high reset of the pointers.
module vxe_vpu_cmd_fifo #(
  parameter int unsigned WIDTH      = 56,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr;
  logic [DEPTH_LOG2:0] rptr;
  logic                do_wr;
  logic                do_rd;

  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                 (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = mem[rptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[DEPTH_LOG2-1:0]] <= wdata;
  end

endmodule

// File: rtl/vxe_vpu_cmd_rx.sv
// VPU command receiver: buffers CU beats and hands them to VPU threads.
// Optional macro VXE_VPU_CMDRX_OPCHECK_EN drops reserved opcodes with an o_err pulse.
module vxe_vpu_cmd_rx
  import vxe_vpu_cmd_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 2,
  parameter int unsigned NTHREADS        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     i_cmd_op,
  input  logic [TH_W-1:0]     i_cmd_th,
  input  logic [PL_W-1:0]     i_cmd_pl,
  input  logic                i_cmd_wr,
  output logic                o_cmd_rdy,
  output logic [NTHREADS-1:0] o_thr_we,
  output logic [OP_W-1:0]     o_thr_op,
  output logic [PL_W-1:0]     o_thr_pl,
  input  logic [NTHREADS-1:0] i_thr_rdy,
  input  logic [NTHREADS-1:0] i_thr_busy,
  output logic                o_busy,
  output logic                o_err
);

  state_t              state, state_n;
  cmd_t                push_cmd, head;
  logic                fifo_empty, fifo_full;
  logic                pop;
  logic                fwd;
  logic [TH_W-1:0]     th_q, th_n;
  logic [NTHREADS-1:0] we_n;
  logic [OP_W-1:0]     op_n;
  logic [PL_W-1:0]     pl_n;

  assign push_cmd = '{op: i_cmd_op, th: i_cmd_th, pl: i_cmd_pl};

  vxe_vpu_cmd_fifo #(
    .WIDTH      ($bits(cmd_t)),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (i_cmd_wr),
    .wdata (push_cmd),
    .rd    (pop),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign o_cmd_rdy = !fifo_full;
  assign o_busy    = !fifo_empty || (state != ST_IDLE) || (|i_thr_busy);

`ifdef VXE_VPU_CMDRX_OPCHECK_EN
  logic err_n;
  assign fwd = !fifo_empty && !is_nop(head.op) && !is_barrier(head.op) &&
               !is_reserved(head.op);
`else
  assign fwd = !fifo_empty && !is_nop(head.op) && !is_barrier(head.op);
  assign o_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    we_n    = o_thr_we;
    op_n    = o_thr_op;
    pl_n    = o_thr_pl;
    th_n    = th_q;
    pop     = 1'b0;
`ifdef VXE_VPU_CMDRX_OPCHECK_EN
    err_n   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (is_nop(head.op)) begin
            pop = 1'b1;
          end else if (is_barrier(head.op)) begin
            state_n = ST_BARR;
`ifdef VXE_VPU_CMDRX_OPCHECK_EN
          end else if (is_reserved(head.op)) begin
            pop   = 1'b1;
            err_n = 1'b1;
`endif
          end else begin
            pop     = 1'b1;
            we_n    = NTHREADS'(1) << head.th;
            op_n    = head.op;
            pl_n    = head.pl;
            th_n    = head.th;
            state_n = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        // Chain straight into the next forwardable head to avoid a bubble.
        if (i_thr_rdy[th_q]) begin
          if (fwd) begin
            pop  = 1'b1;
            we_n = NTHREADS'(1) << head.th;
            op_n = head.op;
            pl_n = head.pl;
            th_n = head.th;
          end else begin
            we_n    = '0;
            state_n = ST_IDLE;
          end
        end
      end
      ST_BARR: begin
        if (i_thr_busy == '0) begin
          pop     = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      o_thr_we <= '0;
      o_thr_op <= '0;
      o_thr_pl <= '0;
      th_q     <= '0;
    end else begin
      state    <= state_n;
      o_thr_we <= we_n;
      o_thr_op <= op_n;
      o_thr_pl <= pl_n;
      th_q     <= th_n;
    end
  end

`ifdef VXE_VPU_CMDRX_OPCHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_err <= 1'b0;
    else     o_err <= err_n;
  end
`endif

endmodule

// File: tb/tb_vxe_vpu_cmd_rx.sv
// Scoreboard bench for vxe_vpu_cmd_rx: directed beats push expected thread
// writes; a negedge monitor pops and compares each completed thread transfer.
module tb_vxe_vpu_cmd_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  i_cmd_op;
  logic [2:0]  i_cmd_th;
  logic [47:0] i_cmd_pl;
  logic        i_cmd_wr;
  logic        o_cmd_rdy;
  logic [7:0]  o_thr_we;
  logic [4:0]  o_thr_op;
  logic [47:0] o_thr_pl;
  logic [7:0]  i_thr_rdy;
  logic [7:0]  i_thr_busy;
  logic        o_busy;
  logic        o_err;

  typedef struct packed {
    logic [7:0]  we;
    logic [4:0]  op;
    logic [47:0] pl;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   err_pending = 0;
  logic prev_err    = 1'b0;

  vxe_vpu_cmd_rx #(
    .FIFO_DEPTH_LOG2 (2),
    .NTHREADS        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_cmd_op   (i_cmd_op),
    .i_cmd_th   (i_cmd_th),
    .i_cmd_pl   (i_cmd_pl),
    .i_cmd_wr   (i_cmd_wr),
    .o_cmd_rdy  (o_cmd_rdy),
    .o_thr_we   (o_thr_we),
    .o_thr_op   (o_thr_op),
    .o_thr_pl   (o_thr_pl),
    .i_thr_rdy  (i_thr_rdy),
    .i_thr_busy (i_thr_busy),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [7:0] we, input logic [4:0] op, input logic [47:0] pl);
    exp_t e;
    e.we = we; e.op = op; e.pl = pl;
    exp_q.push_back(e);
  endtask

  // Returns at posedge+1 of the accepting edge.
  task automatic send(input logic [4:0] op, input logic [2:0] th, input logic [47:0] pl);
    bit ok = 0;
    i_cmd_op = op; i_cmd_th = th; i_cmd_pl = pl; i_cmd_wr = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = o_cmd_rdy;
      @(posedge clk);
      #1;
    end
    i_cmd_wr = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got rdy=0 expected rdy=1 within 50 cycles (op=%0h th=%0d)", op, th);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && (exp_q.size() != 0 || err_pending != 0); i++) begin
      @(posedge clk);
      #1;
    end
    check({name, "_drained"}, 64'(exp_q.size() + err_pending), 64'd0);
    exp_q.delete();
    err_pending = 0;
  endtask

  // Monitor: a thread write completes at the next posedge when its ready is high.
  always @(negedge clk) begin
    if (!rst) begin
      if ((o_thr_we & i_thr_rdy) != 8'h00) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL thr_unexpected: got we=%0h op=%0h pl=%0h expected no write",
                   o_thr_we, o_thr_op, o_thr_pl);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (o_thr_we !== e.we || o_thr_op !== e.op || o_thr_pl !== e.pl) begin
            miscompares++;
            $display("FAIL thr_write: got we=%0h op=%0h pl=%0h expected we=%0h op=%0h pl=%0h",
                     o_thr_we, o_thr_op, o_thr_pl, e.we, e.op, e.pl);
          end
        end
      end
      if (o_err) begin
        vectors++;
        if (err_pending == 0 || prev_err) begin
          miscompares++;
          $display("FAIL err_pulse: got o_err=1 (prev=%0b) expected single pulse, pending=%0d",
                   prev_err, err_pending);
        end else begin
          err_pending--;
        end
      end
      prev_err = o_err;
    end else begin
      prev_err = 1'b0;
    end
  end

  initial begin
    rst = 1'b1;
    i_cmd_op = '0; i_cmd_th = '0; i_cmd_pl = '0; i_cmd_wr = 1'b0;
    i_thr_rdy = 8'hFF; i_thr_busy = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_we",   64'(o_thr_we),  64'h0);
    check("rst_op",   64'(o_thr_op),  64'h0);
    check("rst_pl",   64'(o_thr_pl),  64'h0);
    check("rst_err",  64'(o_err),     64'h0);
    check("rst_busy", 64'(o_busy),    64'h0);
    check("rst_rdy",  64'(o_cmd_rdy), 64'h1);
    @(posedge clk);
    #1;

    // Four beats, all threads ready: one-hot writes on consecutive cycles.
    expect_wr(8'h01, 5'b00001, 48'h0000_1111_0000);
    expect_wr(8'h02, 5'b00001, 48'h0000_1111_0001);
    expect_wr(8'h04, 5'b00001, 48'h0000_1111_0002);
    expect_wr(8'h08, 5'b00001, 48'h0000_1111_0003);
    send(5'b00001, 3'd0, 48'h0000_1111_0000);
    check("lat_first", 64'(o_thr_we), 64'h00);
    send(5'b00001, 3'd1, 48'h0000_1111_0001);
    check("lat_we0", 64'(o_thr_we), 64'h01);
    send(5'b00001, 3'd2, 48'h0000_1111_0002);
    check("lat_we1", 64'(o_thr_we), 64'h02);
    send(5'b00001, 3'd3, 48'h0000_1111_0003);
    check("lat_we2", 64'(o_thr_we), 64'h04);
    @(posedge clk);
    #1;
    check("lat_we3", 64'(o_thr_we), 64'h08);
    drain("burst");

    // Threads stalled: one held in SEND plus four buffered fills the FIFO.
    i_thr_rdy = 8'h00;
    for (int i = 0; i < 5; i++)
      expect_wr(8'h01 << i, 5'b01001, 48'hA5A5_0000_0000 + 48'(i));
    for (int i = 0; i < 5; i++)
      send(5'b01001, 3'(i), 48'hA5A5_0000_0000 + 48'(i));
    @(posedge clk);
    #1;
    check("full_rdy",  64'(o_cmd_rdy), 64'h0);
    check("full_hold", 64'(o_thr_we),  64'h01);
    i_cmd_op = 5'b01111; i_cmd_th = 3'd7; i_cmd_pl = 48'hDEAD_DEAD_DEAD; i_cmd_wr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("full_blocked", 64'(o_cmd_rdy), 64'h0);
    i_cmd_wr = 1'b0;
    i_thr_rdy = 8'hFF;
    drain("full");
    @(posedge clk);
    #1;
    check("full_idle_busy", 64'(o_busy), 64'h0);

    // Barrier holds th=5 until thread 2 goes idle.
    i_thr_busy = 8'h04;
    expect_wr(8'h04, 5'b01000, 48'h2222_2222_2222);
    expect_wr(8'h20, 5'b00010, 48'h5555_5555_5555);
    send(5'b01000, 3'd2, 48'h2222_2222_2222);
    send(5'b11111, 3'd0, 48'h0);
    send(5'b00010, 3'd5, 48'h5555_5555_5555);
    repeat (10) @(posedge clk);
    #1;
    check("barr_hold",  64'(o_thr_we), 64'h00);
    check("barr_busy",  64'(o_busy),   64'h1);
    check("barr_queue", 64'(exp_q.size()), 64'd1);
    i_thr_busy = 8'h00;
    @(posedge clk);
    #1;
    check("barr_pop", 64'(o_thr_we), 64'h00);
    @(posedge clk);
    #1;
    check("barr_release", 64'(o_thr_we), 64'h20);
    drain("barrier");

    // NOP between two commands produces no write.
    expect_wr(8'h02, 5'b00011, 48'h0101_0101_0101);
    expect_wr(8'h40, 5'b00100, 48'h0606_0606_0606);
    send(5'b00011, 3'd1, 48'h0101_0101_0101);
    send(5'b00000, 3'd7, 48'h7777_7777_7777);
    send(5'b00100, 3'd6, 48'h0606_0606_0606);
    drain("nop");

    // Reserved opcode.
`ifdef VXE_VPU_CMDRX_OPCHECK_EN
    err_pending = 1;
`else
    expect_wr(8'h08, 5'b10011, 48'h3333_3333_3333);
`endif
    send(5'b10011, 3'd3, 48'h3333_3333_3333);
    drain("reserved");
    check("reserved_err_low", 64'(o_err), 64'h0);

    // Reset with SEND pending and three entries buffered.
    i_thr_rdy = 8'h00;
    for (int i = 0; i < 4; i++)
      send(5'b00101, 3'(i), 48'hBEEF_0000_0000 + 48'(i));
    @(posedge clk);
    #1;
    check("prerst_we", 64'(o_thr_we), 64'h01);
    #2 rst = 1'b1;
    #1;
    check("async_rst_we", 64'(o_thr_we), 64'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_we",   64'(o_thr_we),  64'h00);
    check("midrst_rdy",  64'(o_cmd_rdy), 64'h1);
    check("midrst_busy", 64'(o_busy),    64'h0);
    check("midrst_op",   64'(o_thr_op),  64'h0);
    check("midrst_pl",   64'(o_thr_pl),  64'h0);
    i_thr_rdy = 8'hFF;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_stale", 64'(o_thr_we), 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
